minterm_window_detector: RTL

Sequential, parametrised successor to the team's fixed 3-variable sum-of-minterms circuit. A serial bit stream is shifted into an N-bit sliding window, and the window is evaluated against a run-time programmable truth table of 2^N minterms. The block produces a registered decision strobe and an optional saturating match counter. It sits between a serial input source and downstream pattern-reporting logic.

---
 rtl/minterm_pkg.sv | 15 +
 rtl/minterm_window_detector_lut.sv | 14 +
 rtl/minterm_window_detector.sv | 108 ++++++++++
 3 files changed

// File: rtl/minterm_pkg.sv
// Shared constants and helpers for the minterm window detector.
package minterm_pkg;

    localparam logic [7:0] TEXTBOOK_MINTERMS = 8'h46;

    function automatic int table_width(input int n);
        return 1 << n;
    endfunction

    // Increments v but sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/minterm_window_detector_lut.sv
// Combinational truth-table lookup: selects one bit of a 2^N-bit table by an N-bit index.
module truth_table_lut
    import minterm_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [table_width(N)-1:0] table_i,
    input  logic [N-1:0]              idx_i,
    output logic                      bit_o
);

    assign bit_o = table_i[idx_i];

endmodule

// File: rtl/minterm_window_detector.sv
// Sliding N-bit window over a serial stream, evaluated against a programmable truth table.
// Optional saturating match counter is built only when MINTERM_COUNT_EN is defined.
module minterm_window_detector
    import minterm_pkg::*;
#(
    parameter int                        N        = 3,
    parameter logic [table_width(N)-1:0] MINTERMS = TEXTBOOK_MINTERMS,
    parameter int                        CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_bit,
    input  logic                      cfg_we,
    input  logic [table_width(N)-1:0] cfg_table,
    output logic [N-1:0]              window,
    output logic                      z,
    output logic                      z_valid,
    output logic [CNT_W-1:0]          match_count
);

    localparam int TW = table_width(N);
    localparam int FW = $clog2(N + 1);

    logic [N-1:0]  window_q, window_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [TW-1:0] table_q, table_d;
    logic          z_q, z_d;
    logic          zv_q, zv_d;
    logic          lut_bit;
    logic          eval;

    // Lookup uses the window value being written this edge and the table still held in table_q.
    truth_table_lut #(.N(N)) u_lut (
        .table_i (table_q),
        .idx_i   (window_d),
        .bit_o   (lut_bit)
    );

    assign eval = in_valid && (fill_q >= FW'(N - 1));

    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        table_d  = table_q;
        z_d      = z_q;
        zv_d     = 1'b0;
        if (in_valid) begin
            window_d = {window_q[N-2:0], in_bit};
            if (fill_q != FW'(N)) begin
                fill_d = fill_q + 1'b1;
            end
        end
        if (eval) begin
            z_d  = lut_bit;
            zv_d = 1'b1;
        end
        if (cfg_we) begin
            table_d = cfg_table;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q <= '0;
            fill_q   <= '0;
            table_q  <= MINTERMS;
            z_q      <= 1'b0;
            zv_q     <= 1'b0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
            table_q  <= table_d;
            z_q      <= z_d;
            zv_q     <= zv_d;
        end
    end

`ifdef MINTERM_COUNT_EN
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (eval && lut_bit) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif

    assign window  = window_q;
    assign z       = z_q;
    assign z_valid = zv_q;

endmodule
